// File: rtl/soc_system_cpu_mul_combine.sv
// rtl/soc_system_cpu_mul_combine.sv - combines 16x16 partial products into the low 32-bit product word
// Build option SOC_SYSTEM_MUL_COMBINE_OUTREG_EN adds an output register stage W (latency 2 instead of 1).
module soc_system_cpu_mul_combine #(
    parameter int MUL_TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          M_mul_cell_p1,
    input  logic [31:0]          M_mul_cell_p2,
    input  logic [31:0]          M_mul_cell_p3,
    input  logic                 M_mul_valid,
    input  logic [MUL_TAG_W-1:0] M_mul_dst,
    input  logic                 M_en,
    input  logic                 M_flush,
    output logic [31:0]          mul_result,
    output logic                 mul_valid,
    output logic [MUL_TAG_W-1:0] mul_dst
);

    logic [16:0]          cross_sum;
    logic [31:0]          combined;

    logic [31:0]          A_result;
    logic                 A_valid;
    logic [MUL_TAG_W-1:0] A_dst;

    // Only the low half of each cross term lands in the low product word;
    // the cross carry and the high halves belong to the upper word.
    always_comb begin
        cross_sum = {1'b0, M_mul_cell_p2[15:0]} + {1'b0, M_mul_cell_p3[15:0]};
        combined  = M_mul_cell_p1 + {cross_sum[15:0], 16'h0000};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_result <= 32'h0;
            A_valid  <= 1'b0;
            A_dst    <= '0;
        end else begin
            if (M_en) begin
                A_result <= combined;
                A_dst    <= M_mul_dst;
            end
            // Flush wins over an entering instruction and applies even while stalled.
            if (M_flush)
                A_valid <= 1'b0;
            else if (M_en)
                A_valid <= M_mul_valid;
        end
    end

`ifdef SOC_SYSTEM_MUL_COMBINE_OUTREG_EN
    logic [31:0]          W_result;
    logic                 W_valid;
    logic [MUL_TAG_W-1:0] W_dst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            W_result <= 32'h0;
            W_valid  <= 1'b0;
            W_dst    <= '0;
        end else begin
            if (M_en) begin
                W_result <= A_result;
                W_dst    <= A_dst;
            end
            if (M_flush)
                W_valid <= 1'b0;
            else if (M_en)
                W_valid <= A_valid;
        end
    end

    assign mul_result = W_result;
    assign mul_valid  = W_valid;
    assign mul_dst    = W_dst;
`else
    assign mul_result = A_result;
    assign mul_valid  = A_valid;
    assign mul_dst    = A_dst;
`endif

endmodule

// File: tb/tb_soc_system_cpu_mul_combine.sv
// tb/tb_soc_system_cpu_mul_combine.sv - directed and random checks of the multiply combine stage
module tb_soc_system_cpu_mul_combine;

    localparam int TAG_W = 5;
`ifdef SOC_SYSTEM_MUL_COMBINE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk;
    logic             reset;
    logic [31:0]      p1, p2, p3;
    logic             in_valid;
    logic [TAG_W-1:0] in_dst;
    logic             en;
    logic             flush;
    logic [31:0]      mul_result;
    logic             mul_valid;
    logic [TAG_W-1:0] mul_dst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             v;
        logic [31:0]      r;
        logic [TAG_W-1:0] d;
    } ent_t;

    ent_t pipe[$];
    logic [31:0] cur_prod;

    soc_system_cpu_mul_combine #(.MUL_TAG_W(TAG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .M_mul_cell_p1 (p1),
        .M_mul_cell_p2 (p2),
        .M_mul_cell_p3 (p3),
        .M_mul_valid   (in_valid),
        .M_mul_dst     (in_dst),
        .M_en          (en),
        .M_flush       (flush),
        .mul_result    (mul_result),
        .mul_valid     (mul_valid),
        .mul_dst       (mul_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t z;
        z = '0;
        pipe = {};
        for (int i = 0; i < LAT; i++) pipe.push_back(z);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {31'b0, mul_valid}, {31'b0, pipe[0].v});
        check({tag, ".result"}, mul_result, pipe[0].r);
        check({tag, ".dst"}, {27'b0, mul_dst}, {27'b0, pipe[0].d});
    endtask

    // Drives one M-stage entry built from full 32-bit sources, clocks it, and
    // compares against the expected true product carried through the model.
    task automatic step(input string tag, input logic v, input logic [TAG_W-1:0] d,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic e, input logic f);
        ent_t n;
        logic [63:0] full;
        p1       = {16'h0, s1[15:0]} * {16'h0, s2[15:0]};
        p2       = {16'h0, s1[15:0]} * {16'h0, s2[31:16]};
        p3       = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
        in_valid = v;
        in_dst   = d;
        en       = e;
        flush    = f;
        full     = {32'h0, s1} * {32'h0, s2};
        cur_prod = full[31:0];
        @(posedge clk);
        if (e) begin
            n.v = v & ~f;
            n.r = cur_prod;
            n.d = d;
            pipe.push_back(n);
            void'(pipe.pop_front());
        end
        if (f) foreach (pipe[i]) pipe[i].v = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic e);
        step(tag, 1'b0, 5'd0, 32'h0, 32'h0, e, 1'b0);
    endtask

    initial begin
        logic [31:0] r1, r2;
        reset = 1'b1; p1 = '0; p2 = '0; p3 = '0;
        in_valid = 1'b0; in_dst = '0; en = 1'b0; flush = 1'b0;
        model_reset();
        #23;
        check_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Worked example from the datasheet.
        step("ex1", 1'b1, 5'd7, 32'h0001_2345, 32'h0001_0002, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) idle("ex1_drain", 1'b1);
        check("ex1.const_result", mul_result, 32'h2347_468A);
        check("ex1.const_valid", {31'b0, mul_valid}, 32'd1);
        check("ex1.const_dst", {27'b0, mul_dst}, 32'd7);

        step("ffff", 1'b1, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) idle("ffff_drain", 1'b1);
        check("ffff.const_result", mul_result, 32'h0000_0001);

        // Back-to-back entries then a stall that must hold the outputs.
        for (int i = 0; i < 3; i++)
            step("b2b", 1'b1, TAG_W'(10 + i), $urandom, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, TAG_W'(20 + i), $urandom, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < LAT; i++) idle("b2b_drain", 1'b1);

        // Flush kills both the in-flight and the entering entry.
        step("fl_a", 1'b1, 5'd4, $urandom, $urandom, 1'b1, 1'b0);
        step("fl_b", 1'b1, 5'd5, $urandom, $urandom, 1'b1, 1'b1);
        step("fl_c", 1'b1, 5'd6, $urandom, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < LAT; i++) idle("fl_drain", 1'b1);

        // Asynchronous reset pulse between clock edges with entries in flight.
        step("rs_a", 1'b1, 5'd8, $urandom, $urandom, 1'b1, 1'b0);
        step("rs_b", 1'b1, 5'd9, $urandom, $urandom, 1'b1, 1'b0);
        en = 1'b0; in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rs_now");
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_outputs("rs_release");
        step("rs_post", 1'b1, 5'd11, $urandom, $urandom, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) idle("rs_post_drain", 1'b1);
        check("rs_post.const_valid", {31'b0, mul_valid}, 32'd1);

        // Nonzero products with no live instruction never raise valid.
        for (int i = 0; i < 4; i++)
            step("novalid", 1'b0, 5'd31, $urandom | 32'h0001_0001, $urandom | 32'h0001_0001, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r1 = $urandom; r2 = $urandom;
            step("rand", ($urandom_range(0, 3) != 0), TAG_W'($urandom), r1, r2,
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_system_cpu_mul_combine.md
# soc_system_cpu_mul_combine

Consumer side of the CPU's 16x16 multiplier cell. It takes the three registered partial products (lo×lo, lo×hi, hi×lo) in the M stage and combines them into the low 32 bits of the 32×32 product. It pipelines the result, with the destination-register tag and valid bit, toward writeback under the shared M-stage enable, and supports pipeline flush. It sits between the multiplier cell and the register-file write mux.

## Interface
- `MUL_TAG_W`, default 5: width of destination-register tag carried alongside the product.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `M_mul_cell_p1`  in  32  lo(src1)×lo(src2), unsigned.
- `M_mul_cell_p2`  in  32  lo(src1)×hi(src2), unsigned.
- `M_mul_cell_p3`  in  32  hi(src1)×lo(src2), unsigned.
- `M_mul_valid`  in  1  partial products in M stage belong to a live MUL instruction.
- `M_mul_dst`  in  MUL_TAG_W  destination tag of the M-stage instruction.
- `M_en`  in  1  pipeline advance; all stage registers load only when high.
- `M_flush`  in  1  kill all in-flight multiply results.
- `mul_result`  out  32  low 32 bits of product.
- `mul_valid`  out  1  `mul_result` and `mul_dst` are valid this cycle.
- `mul_dst`  out  MUL_TAG_W  destination tag matching `mul_result`.

## Operation
- Arithmetic, per M-stage entry:
  - cross = p2[15:0] + p3[15:0], 17 bits; only cross[15:0] is used.
  - result = (p1 + {cross[15:0], 16'h0000}) mod 2^32.
  - p2[31:16], p3[31:16] and cross[16] are discarded; they affect only the upper product word.
- Stage A registers: `A_result`, `A_valid`, `A_dst`.
  - When `M_en`=1: `A_valid` ← `M_mul_valid` & ~`M_flush`; `A_result` and `A_dst` load unconditionally.
  - When `M_en`=0: all A registers hold.
- Flush:
  - `M_flush`=1 clears every valid bit in the block on that edge, regardless of `M_en`.
  - Result/tag registers are not cleared.
  - Flush with `M_en`=1 the same cycle: flush wins, and the entering instruction is also killed.
- `mul_valid` is never asserted for an entry with `M_mul_valid`=0; tag and result travel with their valid bit unchanged.
- Back-to-back: one new product per `M_en` cycle; no bubbles, no internal stall.
- Reset mid-operation: all in-flight valids drop immediately (asynchronous); no partial result is emitted after reset deasserts.

## Timing
- Reset values: `mul_result`=32'h0, `mul_valid`=0, `mul_dst`=0, every internal register 0.
- Latency (macro off): result for partial products present at edge N (with `M_en`=1) appears on outputs after edge N; 1 enabled cycle.
- Latency (macro on): 2 enabled cycles. Cycles with `M_en`=0 do not count toward latency.
- Outputs are registered only; no combinational path from any input to any output.
- Critical path: the 17-bit cross add feeding the upper 16 bits of the 32-bit add. The adder is a single chain, not split across stages.

## Configuration
- `SOC_SYSTEM_MUL_COMBINE_OUTREG_EN` defined:
  - adds stage W (`W_result`, `W_valid`, `W_dst`), loaded from stage A under `M_en`, cleared-valid under `M_flush`;
  - outputs driven from W; latency 2.
- Undefined: outputs driven directly from stage A; latency 1.
- Arithmetic, flush and reset behaviour are identical in both builds.

## Test plan
- src 0x00012345 × 0x00010002 (p1=0x0000468A, p2=0x00002345, p3=0x00000002), valid, dst=7 → `mul_result`=0x2347468A, `mul_dst`=7, `mul_valid`=1 after the configured latency.
- src 0xFFFFFFFF × 0xFFFFFFFF (p1=p2=p3=0xFFFE0001) → `mul_result`=0x00000001; verifies discard of high halves and cross carry.
- Three back-to-back valid entries, `M_en` held 1 → three consecutive `mul_valid` pulses, in order, with matching tags; then `M_en`=0 for 3 cycles → outputs hold unchanged.
- Valid entry in flight, `M_flush`=1 with `M_en`=1 on the next edge → neither the in-flight nor the entering entry produces `mul_valid`; the following unflushed entry emerges normally.
- `reset` pulsed for one cycle asynchronously (not on a clock edge) with valid entries in flight → `mul_valid`=0 and `mul_result`=0 immediately; first post-reset entry appears with normal latency.
- `M_mul_valid`=0 with nonzero partial products → `mul_valid` stays 0 for all cycles.
